// File: rtl/bmp_pkg.sv
// Shared constants, FSM encoding and helpers for the BMP pair source.
// A MEM_RDATA word holds one pixel pair in BMP byte order (B,G,R per pixel).
package bmp_pkg;

  localparam int IMG_WIDTH      = 768;
  localparam int IMG_HEIGHT     = 512;
  localparam int BMP_HEADER_NUM = 54;
  localparam int PAIR_W         = 48;
  localparam int PAIR_NUM       = IMG_WIDTH * IMG_HEIGHT / 2;

  // Byte-lane offsets of MEM_RDATA
  localparam int LANE_B0 = 0;
  localparam int LANE_G0 = 8;
  localparam int LANE_R0 = 16;
  localparam int LANE_B1 = 24;
  localparam int LANE_G1 = 32;
  localparam int LANE_R1 = 40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } frame_state_t;

  // Number of pixel pairs in a frame of w x h pixels
  function automatic int pair_num(input int w, input int h);
    return w * h / 2;
  endfunction

  // Extract one colour byte from a pair word
  function automatic logic [7:0] pair_lane(input logic [PAIR_W-1:0] word, input int lsb);
    logic [PAIR_W-1:0] shifted;
    shifted = word >> lsb;
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/bmp_pair_source_pair_skid_fifo.sv
// Two-entry pair FIFO between the RAM return path and the pixel stream.
// Push and pop may coincide in any state, including full; srst empties it.
module pair_skid_fifo
  import bmp_pkg::*;
#(
  parameter int DATA_W = PAIR_W
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              srst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_r [2];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        cnt_r;
  logic              do_pop_s;
  logic              do_push_s;

  assign do_pop_s  = pop & (cnt_r != 2'd0);
  assign do_push_s = push & ((cnt_r != 2'd2) | do_pop_s);

  // Storage, pointers and occupancy; a full FIFO may push when it pops
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mem_r[0] <= {DATA_W{1'b0}};
      mem_r[1] <= {DATA_W{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else if (srst) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (cnt_r == 2'd2);
  assign empty = (cnt_r == 2'd0);
  assign count = cnt_r;

endmodule

// File: rtl/bmp_pair_source.sv
// Frame source: reads a bottom-up 24-bpp BMP pixel array from a synchronous
// RAM and streams it top-down as pixel pairs on a VALID/READY interface.
// Returned RAM data is offered directly on the stream when the FIFO is empty,
// so the first pair appears the cycle its read data returns.
module bmp_pair_source
  import bmp_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH,
  parameter int HEIGHT = IMG_HEIGHT,
  parameter int ADDR_W = 18
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              START,
  output logic              MEM_RD,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [47:0]       MEM_RDATA,
  output logic              PIX_VALID,
  input  logic              PIX_READY,
  output logic [7:0]        DATA_R0,
  output logic [7:0]        DATA_G0,
  output logic [7:0]        DATA_B0,
  output logic [7:0]        DATA_R1,
  output logic [7:0]        DATA_G1,
  output logic [7:0]        DATA_B1,
  output logic              BUSY,
  output logic              FRAME_DONE
);

  localparam int HALF_W = WIDTH / 2;
  localparam int N      = pair_num(WIDTH, HEIGHT);
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int RL_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int RM_W   = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  // First fetch is the top image line, stored last in the BMP array
  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'((HEIGHT - 1) * HALF_W);
  // From the last pair of a line back to the first pair of the line above it
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(WIDTH - 1);
  localparam logic [RL_W-1:0]   RL_LAST    = RL_W'(HEIGHT - 1);
  localparam logic [RM_W-1:0]   RM_LAST    = RM_W'(HALF_W - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(N - 1);

  frame_state_t      state_r;
  logic              busy_r;
  logic              frame_done_r;
  logic [CNT_W-1:0]  xfer_cnt_r;
  logic [RL_W-1:0]   rl_r;
  logic [RM_W-1:0]   rm_r;
  logic [ADDR_W-1:0] addr_r;
  logic              fetch_left_r;
  logic              inflight_r;

  logic              start_acc_s;
  logic              valid_s;
  logic              pop_s;
  logic [2:0]        occ_s;
  logic              mem_rd_s;
  logic              fifo_push_s;
  logic              fifo_pop_s;
  logic [47:0]       fifo_dout_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [1:0]        fifo_cnt_s;
  logic [47:0]       head_s;

  assign start_acc_s = (state_r == ST_IDLE) & START;

  // A pair is available from the FIFO or from the read returning this cycle
  assign valid_s = ~fifo_empty_s | inflight_r;
  assign pop_s   = valid_s & PIX_READY;

  // Returning data bypasses an empty FIFO when it is consumed immediately
  assign fifo_pop_s  = pop_s & ~fifo_empty_s;
  assign fifo_push_s = inflight_r & ~(fifo_empty_s & PIX_READY) & (~fifo_full_s | fifo_pop_s);

  // Pairs held or on their way, minus the one leaving now
  assign occ_s    = {1'b0, fifo_cnt_s} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign mem_rd_s = (state_r == ST_RUN) & fetch_left_r & (occ_s < 3'd2);

  // Head-of-stream selection: FIFO first, then returning RAM data
  always_comb begin
    head_s = 48'd0;
    if (!fifo_empty_s) begin
      head_s = fifo_dout_s;
    end else if (inflight_r) begin
      head_s = MEM_RDATA;
    end else begin
      head_s = 48'd0;
    end
  end

  // Frame FSM with registered BUSY/FRAME_DONE and the transfer counter
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      xfer_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          frame_done_r <= 1'b0;
          xfer_cnt_r   <= {CNT_W{1'b0}};
          if (START) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (pop_s && (xfer_cnt_r == CNT_LAST)) begin
            state_r      <= ST_DONE;
            frame_done_r <= 1'b1;
          end else if (pop_s) begin
            xfer_cnt_r   <= xfer_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            frame_done_r <= 1'b0;
          end else begin
            frame_done_r <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r      <= ST_IDLE;
          busy_r       <= 1'b0;
          frame_done_r <= 1'b0;
          xfer_cnt_r   <= {CNT_W{1'b0}};
        end
        default: begin
          state_r      <= ST_IDLE;
          busy_r       <= 1'b0;
          frame_done_r <= 1'b0;
          xfer_cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Fetch position and flipped RAM address, advanced incrementally per read
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rl_r         <= {RL_W{1'b0}};
      rm_r         <= {RM_W{1'b0}};
      addr_r       <= {ADDR_W{1'b0}};
      fetch_left_r <= 1'b0;
    end else if (start_acc_s) begin
      rl_r         <= {RL_W{1'b0}};
      rm_r         <= {RM_W{1'b0}};
      addr_r       <= ADDR_FIRST;
      fetch_left_r <= 1'b1;
    end else if (mem_rd_s) begin
      if ((rm_r == RM_LAST) && (rl_r == RL_LAST)) begin
        fetch_left_r <= 1'b0;
      end else if (rm_r == RM_LAST) begin
        rm_r   <= {RM_W{1'b0}};
        rl_r   <= rl_r + {{(RL_W-1){1'b0}}, 1'b1};
        addr_r <= addr_r - ROW_STEP;
      end else begin
        rm_r   <= rm_r + {{(RM_W-1){1'b0}}, 1'b1};
        addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end else begin
      fetch_left_r <= fetch_left_r;
    end
  end

  // A read issued this cycle returns data next cycle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= mem_rd_s;
    end
  end

  pair_skid_fifo #(
    .DATA_W (48)
  ) u_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .srst    (start_acc_s),
    .push    (fifo_push_s),
    .pop     (fifo_pop_s),
    .din     (MEM_RDATA),
    .dout    (fifo_dout_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_cnt_s)
  );

  assign MEM_RD     = mem_rd_s;
  assign MEM_ADDR   = addr_r;
  assign PIX_VALID  = valid_s;
  assign DATA_B0    = pair_lane(head_s, LANE_B0);
  assign DATA_G0    = pair_lane(head_s, LANE_G0);
  assign DATA_R0    = pair_lane(head_s, LANE_R0);
  assign DATA_B1    = pair_lane(head_s, LANE_B1);
  assign DATA_G1    = pair_lane(head_s, LANE_G1);
  assign DATA_R1    = pair_lane(head_s, LANE_R1);
  assign BUSY       = busy_r;
  assign FRAME_DONE = frame_done_r;

endmodule

// File: tb/tb_bmp_pair_source.sv
// Directed bench for bmp_pair_source: an 8x4 instance against a small RAM
// model, plus a default 768x512 instance checked over its first lines.
module tb_bmp_pair_source;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        START;
  logic        MEM_RD;
  logic [4:0]  MEM_ADDR;
  logic [47:0] MEM_RDATA;
  logic        PIX_VALID;
  logic        PIX_READY;
  logic [7:0]  DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;
  logic        BUSY;
  logic        FRAME_DONE;

  logic        start2;
  logic        rd2;
  logic [17:0] addr2;
  logic [47:0] rdata2;
  logic        valid2;
  logic        ready2;
  logic [7:0]  r0_2, g0_2, b0_2, r1_2, g1_2, b1_2;
  logic        busy2;
  logic        done2;

  logic [47:0] ram [0:15];
  logic [47:0] first_pair;
  int          checks = 0;
  int          errors = 0;

  always #5 HCLK = ~HCLK;

  bmp_pair_source #(.WIDTH(8), .HEIGHT(4), .ADDR_W(5)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .START(START),
    .MEM_RD(MEM_RD), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA),
    .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
    .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
  );

  bmp_pair_source dut_full (
    .HCLK(HCLK), .HRESETn(HRESETn), .START(start2),
    .MEM_RD(rd2), .MEM_ADDR(addr2), .MEM_RDATA(rdata2),
    .PIX_VALID(valid2), .PIX_READY(ready2),
    .DATA_R0(r0_2), .DATA_G0(g0_2), .DATA_B0(b0_2),
    .DATA_R1(r1_2), .DATA_G1(g1_2), .DATA_B1(b1_2),
    .BUSY(busy2), .FRAME_DONE(done2)
  );

  // Synchronous RAM models: data one cycle after the read strobe
  always @(posedge HCLK) begin
    if (MEM_RD) MEM_RDATA <= ram[MEM_ADDR[3:0]];
    if (rd2)    rdata2    <= {30'd0, addr2};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address of pair j in top-down order for an 8x4 image
  function automatic int exp_addr(input int j);
    return (3 - j / 4) * 4 + (j % 4);
  endfunction

  // Modes: 0 READY=1, 1 READY 1,0,0,1, 2 READY low for 10 cycles, 3 READY=1 with extra STARTs
  task automatic run_frame(input int mode, input int abort_after);
    int j = 0;
    int reads = 0;
    int dones = 0;
    int done_t = -1;
    int third_addr = -1;
    logic exp_valid, exp_rd, exp_busy, pop, prev_stall;
    logic [47:0] cur, prev_data;
    prev_stall = 1'b0;
    prev_data  = 48'd0;
    for (int t = 0; t < 200; t++) begin
      START = (t == 0) || (mode == 3 && (t == 5 || t == 18));
      case (mode)
        1:       PIX_READY = ((t % 4) == 0) || ((t % 4) == 3);
        2:       PIX_READY = (t > 10);
        default: PIX_READY = 1'b1;
      endcase
      @(negedge HCLK);
      cur = {DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0};
      exp_valid = (reads - j) > 0;
      chk("pix_valid", 64'(PIX_VALID), 64'(exp_valid));
      pop = exp_valid & PIX_READY;
      exp_rd = (t >= 1) && (reads < 16) && ((reads - j - (pop ? 1 : 0)) < 2);
      chk("mem_rd", 64'(MEM_RD), 64'(exp_rd));
      if (MEM_RD) begin
        chk("mem_addr", 64'(MEM_ADDR), 64'(exp_addr(reads)));
        if (reads == 2) third_addr = int'(MEM_ADDR);
      end
      if (exp_valid) chk("pair_data", cur, ram[exp_addr(j)]);
      if (prev_stall) chk("hold_data", cur, prev_data);
      if (pop && (mode == 0 || mode == 3)) chk("xfer_cycle", 64'(t), 64'(j + 2));
      if (pop && j == 0) first_pair = cur;
      if (FRAME_DONE) begin
        dones++;
        done_t = t;
      end
      exp_busy = (t >= 1) && (dones == 0 || t == done_t);
      chk("busy", 64'(BUSY), 64'(exp_busy));
      if (mode == 2 && t == 10) chk("reads_stalled", 64'(reads), 64'd2);
      prev_stall = exp_valid & ~PIX_READY;
      prev_data  = cur;
      if (MEM_RD) reads++;
      if (pop) j++;
      @(posedge HCLK);
      #1;
      if (abort_after > 0 && j == abort_after) break;
      if (dones > 0 && t >= done_t + 2) break;
    end
    START = 1'b0;
    if (abort_after > 0) begin
      chk("abort_dones", 64'(dones), 64'd0);
    end else begin
      chk("xfer_total", 64'(j), 64'd16);
      chk("read_total", 64'(reads), 64'd16);
      chk("frame_done_count", 64'(dones), 64'd1);
      if (mode == 0 || mode == 3) chk("frame_done_cycle", 64'(done_t), 64'd18);
      if (mode == 2) chk("resume_addr", 64'(third_addr), 64'd14);
    end
  endtask

  task automatic idle_check(input int cycles, input logic expect_zero_outputs);
    for (int i = 0; i < cycles; i++) begin
      @(negedge HCLK);
      chk("idle_mem_rd", 64'(MEM_RD), 64'd0);
      chk("idle_valid", 64'(PIX_VALID), 64'd0);
      chk("idle_busy", 64'(BUSY), 64'd0);
      chk("idle_done", 64'(FRAME_DONE), 64'd0);
      if (expect_zero_outputs) begin
        chk("rst_addr", 64'(MEM_ADDR), 64'd0);
        chk("rst_data", {DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0}, 48'd0);
      end
      @(posedge HCLK);
      #1;
    end
  endtask

  initial begin
    int reads2;
    logic any_done2;
    HRESETn   = 1'b0;
    START     = 1'b0;
    PIX_READY = 1'b0;
    start2    = 1'b0;
    ready2    = 1'b1;
    for (int k = 0; k < 16; k++) ram[k] = 48'(k);

    // Reset state
    idle_check(2, 1'b1);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Continuous READY frame with word k = k
    run_frame(0, 0);
    idle_check(2, 1'b0);

    // Byte mapping of the first pair, under a 1,0,0,1 READY pattern
    ram[12] = 48'h665544332211;
    run_frame(1, 0);
    chk("first_b0", 64'(first_pair[7:0]),   64'h11);
    chk("first_g0", 64'(first_pair[15:8]),  64'h22);
    chk("first_r0", 64'(first_pair[23:16]), 64'h33);
    chk("first_b1", 64'(first_pair[31:24]), 64'h44);
    chk("first_g1", 64'(first_pair[39:32]), 64'h55);
    chk("first_r1", 64'(first_pair[47:40]), 64'h66);
    chk("dut_b0_port_map", {40'd0, first_pair[7:0]}, 48'h11);

    // Consumer stalled for 10 cycles after START
    run_frame(2, 0);

    // Reset in the middle of a frame, then a clean frame
    run_frame(0, 5);
    HRESETn = 1'b0;
    idle_check(3, 1'b1);
    HRESETn = 1'b1;
    idle_check(3, 1'b0);
    run_frame(0, 0);

    // START pulses during RUN and during DONE are ignored
    run_frame(3, 0);
    idle_check(4, 1'b0);

    // Default 768x512 instance: first address, first pair, line wrap
    reads2    = 0;
    any_done2 = 1'b0;
    start2    = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(negedge HCLK);
      if (t == 1) begin
        chk("full_first_rd", 64'(rd2), 64'd1);
        chk("full_first_addr", 64'(addr2), 64'd196224);
      end
      if (t == 2) begin
        chk("full_first_valid", 64'(valid2), 64'd1);
        chk("full_first_pair", {r1_2, g1_2, b1_2, r0_2, g0_2, b0_2}, 48'h00000002FE80);
      end
      if (rd2) begin
        if (reads2 == 384) chk("full_wrap_addr", 64'(addr2), 64'd195840);
        reads2++;
      end
      if (done2) any_done2 = 1'b1;
      @(posedge HCLK);
      #1;
      start2 = 1'b0;
    end
    chk("full_reads", 64'(reads2 > 384), 64'd1);
    chk("full_busy", 64'(busy2), 64'd1);
    chk("full_no_done", 64'(any_done2), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
